// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module muldiv_unit #(
   parameter int DATA_SIZE = 32,
   parameter int OP_SIZE   = 3,
   parameter int CNT_SIZE  = 6
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [OP_SIZE-1:0]   i_op,
   input  logic                 i_flush,
   input  logic [DATA_SIZE-1:0] i_A,
   input  logic [DATA_SIZE-1:0] i_B,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_div_zero,
   output logic [DATA_SIZE-1:0] o_hi,
   output logic [DATA_SIZE-1:0] o_lo
);
   localparam int W = DATA_SIZE;
   localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2;

   logic [1:0]          r_state, w_next;
   logic [CNT_SIZE-1:0] r_cnt;
   logic [2*W-1:0]      r_p;
   logic [W-1:0]        r_a, r_b, r_rem, r_hi, r_lo;
   logic                r_is_div, r_dz, r_sign_q, r_sign_r, r_done, r_div_zero;
   logic                w_go, w_md_go, w_mt_go, w_fin, w_last;
   logic                w_md, w_sgn, w_div_op, w_bz, w_ge;
   logic [W-1:0]        w_abs_a, w_abs_b, w_diff, w_q, w_r, w_hi_fix, w_lo_fix;
   logic [W:0]          w_sum, w_sh;
   logic [2*W-1:0]      w_prod;

   assign w_md     = i_op < OP_SIZE'(4);
   assign w_sgn    = i_op == OP_SIZE'(0) || i_op == OP_SIZE'(2);
   assign w_div_op = i_op == OP_SIZE'(2) || i_op == OP_SIZE'(3);
   assign w_bz     = i_B == '0;
   assign w_abs_a  = (w_sgn && i_A[W-1]) ? -i_A : i_A;
   assign w_abs_b  = (w_sgn && i_B[W-1]) ? -i_B : i_B;
   assign w_last   = r_cnt == CNT_SIZE'(W-1);

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;

   always_comb begin
      w_next = i_flush ? S_IDLE :
               (r_state == S_CALC) ? (w_last ? S_FIX : S_CALC) :
               (r_state == S_IDLE && w_md_go) ? ((w_div_op && w_bz) ? S_FIX : S_CALC) :
               S_IDLE;
   end

   always_comb begin
      o_busy  = r_state != S_IDLE;
      w_go    = i_start && !i_flush && r_state == S_IDLE;
      w_md_go = w_go && w_md;
      w_mt_go = w_go && (i_op == OP_SIZE'(4) || i_op == OP_SIZE'(5));
      w_fin   = r_state == S_FIX && !i_flush;
   end

   // multiply: add multiplicand into the upper half, shift product right
   assign w_sum  = {1'b0, r_p[2*W-1:W]} + {1'b0, r_p[0] ? r_a : {W{1'b0}}};
   // divide: shift next dividend bit into the remainder, subtract if it fits
   assign w_sh   = {r_rem, r_p[W-1]};
   assign w_ge   = w_sh >= {1'b0, r_b};
   assign w_diff = w_sh[W-1:0] - r_b;

   assign w_prod   = r_sign_q ? -r_p : r_p;
   assign w_q      = r_sign_q ? -r_p[W-1:0] : r_p[W-1:0];
   assign w_r      = r_sign_r ? -r_rem : r_rem;
   assign w_hi_fix = r_dz ? r_a : r_is_div ? w_r : w_prod[2*W-1:W];
   assign w_lo_fix = r_dz ? {W{1'b1}} : r_is_div ? w_q : w_prod[W-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_p        <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_rem      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_is_div   <= 1'b0;
         r_dz       <= 1'b0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done     <= w_fin;
         r_div_zero <= w_fin && r_dz;
         if (w_md_go) begin
            r_is_div <= w_div_op;
            r_dz     <= w_div_op && w_bz;
            r_sign_q <= w_sgn && (i_A[W-1] ^ i_B[W-1]);
            r_sign_r <= w_sgn && i_A[W-1];
            r_a      <= (w_div_op && w_bz) ? i_A : w_abs_a;
            r_b      <= w_abs_b;
            r_cnt    <= '0;
            r_p      <= {{W{1'b0}}, w_div_op ? w_abs_a : w_abs_b};
            r_rem    <= '0;
         end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            r_p   <= r_is_div ? {r_p[2*W-1:W], r_p[W-2:0], w_ge} : {w_sum, r_p[W-1:1]};
            if (r_is_div) r_rem <= w_ge ? w_diff : w_sh[W-1:0];
         end
         if (w_mt_go && i_op == OP_SIZE'(4)) r_hi <= i_A;
         if (w_mt_go && i_op == OP_SIZE'(5)) r_lo <= i_A;
         if (w_fin) begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
         end
      end
   end

   assign o_done     = r_done;
   assign o_div_zero = r_div_zero;
   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;
   logic        clk = 0, rst_n = 0, i_start = 0, i_flush = 0;
   logic [2:0]  i_op = '0;
   logic [31:0] i_A = '0, i_B = '0;
   logic        o_busy, o_done, o_div_zero;
   logic [31:0] o_hi, o_lo;
   int total = 0, bad = 0;

   muldiv_unit dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_op(i_op), .i_flush(i_flush),
      .i_A(i_A), .i_B(i_B), .o_busy(o_busy), .o_done(o_done), .o_div_zero(o_div_zero),
      .o_hi(o_hi), .o_lo(o_lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // returns {div_zero, hi, lo}
   function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa = a, sb = b, q, m;
      logic [63:0] ua = {32'b0, a}, ub = {32'b0, b};
      longint p;
      case (op)
         3'd0: begin p = longint'(sa) * longint'(sb); return {1'b0, p}; end
         3'd1: return {1'b0, ua * ub};
         default: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            if (op == 3'd3) return {1'b0, a % b, a / b};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
            q = sa / sb;
            m = sa % sb;
            return {1'b0, m, q};
         end
      endcase
   endfunction

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      i_start = 1; i_op = op; i_A = a; i_B = b;
      @(negedge clk);
      i_start = 0;
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [64:0] e = ref_model(op, a, b);
      int lat = (op[1] && b == 0) ? 1 : 33;
      int n = 0, nb;
      start_op(op, a, b);
      nb = int'(o_busy);
      while (!o_done && n < 100) begin
         @(negedge clk);
         n++;
         nb += int'(o_busy);
      end
      chk({tag, "_latency"}, 64'(n), 64'(lat));
      chk({tag, "_busy_cycles"}, 64'(nb), 64'(lat));
      chk({tag, "_hi"}, {32'b0, o_hi}, {32'b0, e[63:32]});
      chk({tag, "_lo"}, {32'b0, o_lo}, {32'b0, e[31:0]});
      chk({tag, "_div_zero"}, {63'b0, o_div_zero}, {63'b0, e[64]});
   endtask

   initial begin
      logic [31:0] a, b, hi0, lo0;
      logic [2:0]  op;
      logic [64:0] e;
      int n, nd, nbusy;
      repeat (2) @(negedge clk);
      chk("reset_state", {o_busy, o_done, o_div_zero, o_hi, o_lo}, 64'h0);
      rst_n = 1;

      run("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
      @(negedge clk);
      chk("done_one_cycle", {62'b0, o_done, o_busy}, 64'h0);
      run("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
      run("divu", 3'd3, 32'd7, 32'd2);
      run("div_zero", 3'd2, 32'd5, 32'd0);
      @(negedge clk);
      chk("div_zero_pulse", {62'b0, o_div_zero, o_done}, 64'h0);
      run("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

      // start accepted in the cycle o_done is high
      run("mult_b2b", 3'd0, 32'h1234_5678, 32'h8765_4321);
      i_start = 1; i_op = 3'd5; i_A = 32'h00C0_FFEE;
      @(negedge clk);
      i_start = 0;
      chk("start_on_done", {o_busy, o_lo}, {1'b0, 32'h00C0_FFEE});

      // flush mid-multiply
      hi0 = o_hi; lo0 = o_lo;
      start_op(3'd0, 32'd99, 32'd77);
      repeat (9) @(negedge clk);
      i_flush = 1;
      @(negedge clk);
      i_flush = 0;
      chk("flush_idle", {62'b0, o_busy, o_done}, 64'h0);
      nd = 0;
      repeat (40) begin @(negedge clk); nd += int'(o_done); end
      chk("flush_no_done", 64'(nd), 64'h0);
      chk("flush_keep_hilo", {o_hi, o_lo}, {hi0, lo0});

      // flush in idle suppresses MTHI
      i_start = 1; i_op = 3'd4; i_A = 32'hDEAD_BEEF; i_flush = 1;
      @(negedge clk);
      i_start = 0; i_flush = 0;
      chk("flush_idle_mthi", {32'b0, o_hi}, {32'b0, hi0});

      // second start while busy is ignored
      e = ref_model(3'd1, 32'hABCD_0123, 32'h0000_F00D);
      start_op(3'd1, 32'hABCD_0123, 32'h0000_F00D);
      repeat (5) @(negedge clk);
      i_start = 1; i_op = 3'd3; i_A = 32'd100; i_B = 32'd3;
      @(negedge clk);
      i_start = 0;
      n = 6;
      while (!o_done && n < 100) begin @(negedge clk); n++; end
      chk("busy_ignore_latency", 64'(n), 64'd33);
      chk("busy_ignore_result", {o_hi, o_lo}, e[63:0]);
      repeat (3) @(negedge clk);
      chk("busy_ignore_no_queue", {63'b0, o_busy}, 64'h0);

      // MTHI then MTLO on consecutive cycles
      nbusy = 0;
      i_start = 1; i_op = 3'd4; i_A = 32'h1234;
      @(negedge clk);
      nbusy += int'(o_busy);
      i_op = 3'd5; i_A = 32'h5678;
      @(negedge clk);
      nbusy += int'(o_busy);
      i_start = 0;
      chk("mthi_mtlo", {o_hi, o_lo}, {32'h1234, 32'h5678});
      chk("mt_no_busy", 64'(nbusy), 64'h0);

      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
         if (op != 3'd3 && b == 0) b = 32'd1;
         run($sformatf("rnd%0d_op%0d", i, op), op, a, b);
      end

      // asynchronous reset mid-divide
      start_op(3'd2, 32'h7654_3210, 32'd13);
      repeat (5) @(negedge clk);
      #2 rst_n = 0;
      #1 chk("async_reset", {o_busy, o_done, o_div_zero, o_hi, o_lo}, 64'h0);
      @(negedge clk);
      rst_n = 1;
      nd = 0;
      repeat (40) begin @(negedge clk); nd += int'(o_done) + int'(o_busy); end
      chk("reset_no_result", {31'b0, o_hi, o_lo} | 64'(nd), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
